// File: rtl/gpu_video_pkg.sv
// ============================================================================
// gpu_video_pkg : shared video timing constants, control bundle, RGB332 helper
// Rev 1.0
// ============================================================================
`default_nettype none

package gpu_video_pkg;

  localparam int c_DEF_WIDTH  = 640;
  localparam int c_DEF_HEIGHT = 480;
  localparam int c_DEF_H_FP   = 16;
  localparam int c_DEF_H_SYNC = 96;
  localparam int c_DEF_H_BP   = 48;
  localparam int c_DEF_V_FP   = 10;
  localparam int c_DEF_V_SYNC = 2;
  localparam int c_DEF_V_BP   = 33;

  // Control bits carried alongside the pixel fetch; syncs kept active-high here.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } vid_ctl_t;

  function automatic int h_total(input int width, input int scale,
                                 input int fp, input int sync, input int bp);
    return width * scale + fp + sync + bp;
  endfunction

  function automatic int v_total(input int height, input int scale,
                                 input int fp, input int sync, input int bp);
    return height * scale + fp + sync + bp;
  endfunction

  function automatic logic [23:0] rgb332_to_888(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// video_timing_gen : raster counters, sync/active decode, scan_enable gating
// Rev 1.0
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_W      = 10,
  parameter int V_W      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_scan_enable,
  output logic [H_W-1:0] o_h_cnt,
  output logic [V_W-1:0] o_v_cnt,
  output logic           o_active,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_frame_start,
  output logic           o_frame_wrap
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;
  logic           r_hold;
  logic           w_run;
  logic           w_h_last;
  logic           w_v_last;
  logic           w_wrap;
  logic           w_active;

  // While holding, a high scan_enable lets the current clock already count.
  assign w_run    = ~r_hold | i_scan_enable;
  assign w_h_last = (r_h_cnt == H_W'(c_H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == V_W'(c_V_TOTAL - 1));
  assign w_wrap   = w_run & w_h_last & w_v_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hold  <= 1'b0;
    end else begin
      if (w_run) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
        end
      end
      if (w_wrap)
        r_hold <= ~i_scan_enable;
      else if (i_scan_enable)
        r_hold <= 1'b0;
    end
  end

  assign w_active = w_run & (r_h_cnt < H_W'(H_ACTIVE)) & (r_v_cnt < V_W'(V_ACTIVE));

  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_active      = w_active;
  assign o_hsync       = w_run & (r_h_cnt >= H_W'(H_ACTIVE + H_FP))
                               & (r_h_cnt <  H_W'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vsync       = w_run & (r_v_cnt >= V_W'(V_ACTIVE + V_FP))
                               & (r_v_cnt <  V_W'(V_ACTIVE + V_FP + V_SYNC));
  assign o_frame_start = w_active & (r_h_cnt == '0) & (r_v_cnt == '0);
  assign o_frame_wrap  = w_wrap;

endmodule

`default_nettype wire

// File: rtl/fbuf_video_scanout.sv
// ============================================================================
// fbuf_video_scanout : framebuffer BRAM port-B scanout with RGB332 expansion
// Rev 1.0
// ============================================================================
`default_nettype none

module fbuf_video_scanout
  import gpu_video_pkg::*;
#(
  parameter int FRAME_WIDTH_SCALED  = c_DEF_WIDTH,
  parameter int FRAME_HEIGHT_SCALED = c_DEF_HEIGHT,
  parameter int SCALE               = 1,
  parameter int H_FP                = c_DEF_H_FP,
  parameter int H_SYNC              = c_DEF_H_SYNC,
  parameter int H_BP                = c_DEF_H_BP,
  parameter int V_FP                = c_DEF_V_FP,
  parameter int V_SYNC              = c_DEF_V_SYNC,
  parameter int V_BP                = c_DEF_V_BP,
  parameter bit SYNC_ACTIVE_HIGH    = 1'b0,
  parameter int RD_LATENCY          = 1,
  parameter int FBUF_ADDR_WIDTH     = 19,
  parameter int FBUF_DATA_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_scan_enable,
  output logic                       o_fbuf_en_rd,
  output logic [FBUF_ADDR_WIDTH-1:0] o_fbuf_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] i_fbuf_rdata,
  output logic                       o_vid_de,
  output logic                       o_vid_hsync,
  output logic                       o_vid_vsync,
  output logic [23:0]                o_vid_rgb,
  output logic                       o_frame_start
);

  localparam int c_H_ACTIVE = FRAME_WIDTH_SCALED * SCALE;
  localparam int c_V_ACTIVE = FRAME_HEIGHT_SCALED * SCALE;
  localparam int c_H_TOTAL  = h_total(FRAME_WIDTH_SCALED, SCALE, H_FP, H_SYNC, H_BP);
  localparam int c_V_TOTAL  = v_total(FRAME_HEIGHT_SCALED, SCALE, V_FP, V_SYNC, V_BP);
  localparam int c_H_W      = $clog2(c_H_TOTAL);
  localparam int c_V_W      = $clog2(c_V_TOTAL);
  localparam int c_PIPE     = RD_LATENCY + 2;
  localparam logic [1:0] c_SUB_LAST = 2'(SCALE - 1);

  logic [c_H_W-1:0]           w_h_cnt;
  logic [c_V_W-1:0]           w_v_cnt;
  logic                       w_active0;
  logic                       w_hsync0;
  logic                       w_vsync0;
  logic                       w_fs0;
  logic                       w_frame_wrap;
  logic                       w_line_end;
  logic                       w_last_line;
  logic [FBUF_ADDR_WIDTH-1:0] w_addr;

  logic [1:0]                 r_x_sub;
  logic [1:0]                 r_y_sub;
  logic [FBUF_ADDR_WIDTH-1:0] r_col;
  logic [FBUF_ADDR_WIDTH-1:0] r_line_base;
  logic                       r_en_rd;
  logic [FBUF_ADDR_WIDTH-1:0] r_addr;
  vid_ctl_t                   r_ctl [c_PIPE];
  logic [23:0]                r_rgb;

  video_timing_gen #(
    .H_ACTIVE (c_H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (c_V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_W      (c_H_W),
    .V_W      (c_V_W)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_scan_enable (i_scan_enable),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_active      (w_active0),
    .o_hsync       (w_hsync0),
    .o_vsync       (w_vsync0),
    .o_frame_start (w_fs0),
    .o_frame_wrap  (w_frame_wrap)
  );

  assign w_line_end  = w_active0 & (w_h_cnt == c_H_W'(c_H_ACTIVE - 1));
  assign w_last_line = (w_v_cnt == c_V_W'(c_V_ACTIVE - 1));
  assign w_addr      = r_line_base + r_col;

  // Incremental address: line_base steps one framebuffer row every SCALE output lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_sub     <= '0;
      r_y_sub     <= '0;
      r_col       <= '0;
      r_line_base <= '0;
    end else begin
      if (w_line_end) begin
        r_x_sub <= '0;
        r_col   <= '0;
        if (w_last_line) begin
          r_y_sub     <= '0;
          r_line_base <= '0;
        end else if (r_y_sub == c_SUB_LAST) begin
          r_y_sub     <= '0;
          r_line_base <= r_line_base + FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED);
        end else begin
          r_y_sub <= r_y_sub + 1'b1;
        end
      end else if (w_active0) begin
        if (r_x_sub == c_SUB_LAST) begin
          r_x_sub <= '0;
          r_col   <= r_col + 1'b1;
        end else begin
          r_x_sub <= r_x_sub + 1'b1;
        end
      end
      if (w_frame_wrap) begin
        r_y_sub     <= '0;
        r_line_base <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en_rd <= 1'b0;
      r_addr  <= '0;
      r_rgb   <= '0;
      for (int i = 0; i < c_PIPE; i++) r_ctl[i] <= '0;
    end else begin
      r_en_rd <= w_active0;
      if (w_active0) r_addr <= w_addr;
      r_ctl[0] <= '{de: w_active0, hs: w_hsync0, vs: w_vsync0, fs: w_fs0};
      for (int i = 1; i < c_PIPE; i++) r_ctl[i] <= r_ctl[i-1];
      // Read data lines up with the control slot RD_LATENCY clocks past stage 1.
      r_rgb <= r_ctl[RD_LATENCY].de ? rgb332_to_888(i_fbuf_rdata[7:0]) : 24'h0;
    end
  end

  assign o_fbuf_en_rd  = r_en_rd;
  assign o_fbuf_addr   = r_addr;
  assign o_vid_de      = r_ctl[c_PIPE-1].de;
  assign o_vid_hsync   = SYNC_ACTIVE_HIGH ? r_ctl[c_PIPE-1].hs : ~r_ctl[c_PIPE-1].hs;
  assign o_vid_vsync   = SYNC_ACTIVE_HIGH ? r_ctl[c_PIPE-1].vs : ~r_ctl[c_PIPE-1].vs;
  assign o_vid_rgb     = r_rgb;
  assign o_frame_start = r_ctl[c_PIPE-1].fs;

endmodule

`default_nettype wire

// File: tb/tb_fbuf_video_scanout.sv
// ============================================================================
// tb_fbuf_video_scanout : directed checks on default, 2x-scaled and tiny rasters
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fbuf_video_scanout;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scan_en_sm = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // d_: default 640x480, s_: 320x240 SCALE=2, m_: 16x8 SCALE=2 with short porches
  logic        d_en, s_en, m_en;
  logic [18:0] d_addr, s_addr, m_addr;
  logic [7:0]  d_rdata = 8'h0, s_rdata = 8'h0, m_rdata = 8'h0;
  logic        d_de, s_de, m_de, d_hs, s_hs, m_hs, d_vs, s_vs, m_vs, d_fs, s_fs, m_fs;
  logic [23:0] d_rgb, s_rgb, m_rgb;

  function automatic logic [7:0] mem_rd(input logic [18:0] a);
    case (a)
      19'd0:   return 8'hE0;
      19'd1:   return 8'h1C;
      19'd2:   return 8'h03;
      19'd3:   return 8'hB6;
      default: return a[7:0];
    endcase
  endfunction

  always @(posedge clk) if (d_en) d_rdata <= mem_rd(d_addr);
  always @(posedge clk) if (s_en) s_rdata <= mem_rd(s_addr);
  always @(posedge clk) if (m_en) m_rdata <= mem_rd(m_addr);

  fbuf_video_scanout dut (
    .clk(clk), .rst_n(rst_n), .i_scan_enable(1'b1),
    .o_fbuf_en_rd(d_en), .o_fbuf_addr(d_addr), .i_fbuf_rdata(d_rdata),
    .o_vid_de(d_de), .o_vid_hsync(d_hs), .o_vid_vsync(d_vs),
    .o_vid_rgb(d_rgb), .o_frame_start(d_fs)
  );

  fbuf_video_scanout #(.FRAME_WIDTH_SCALED(320), .FRAME_HEIGHT_SCALED(240), .SCALE(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .i_scan_enable(1'b1),
    .o_fbuf_en_rd(s_en), .o_fbuf_addr(s_addr), .i_fbuf_rdata(s_rdata),
    .o_vid_de(s_de), .o_vid_hsync(s_hs), .o_vid_vsync(s_vs),
    .o_vid_rgb(s_rgb), .o_frame_start(s_fs)
  );

  // Raster: H 32+4+6+5 = 47, V 16+2+3+4 = 25, frame = 1175 clocks
  fbuf_video_scanout #(.FRAME_WIDTH_SCALED(16), .FRAME_HEIGHT_SCALED(8), .SCALE(2),
                       .H_FP(4), .H_SYNC(6), .H_BP(5), .V_FP(2), .V_SYNC(3), .V_BP(4)) dut_sm (
    .clk(clk), .rst_n(rst_n), .i_scan_enable(scan_en_sm),
    .o_fbuf_en_rd(m_en), .o_fbuf_addr(m_addr), .i_fbuf_rdata(m_rdata),
    .o_vid_de(m_de), .o_vid_hsync(m_hs), .o_vid_vsync(m_vs),
    .o_vid_rgb(m_rgb), .o_frame_start(m_fs)
  );

  // Sample point is 1 time unit after the edge that made cyc == t.
  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 100000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cyc < t) begin
      checks++; failures++;
      $display("FAIL wait_cyc timeout got=%0d want=%0d", cyc, t);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_en_sm = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (d_de   !== 1'b0)  begin failures++; $display("FAIL rst_de got=%b want=0", d_de); end
    checks++; if (d_en   !== 1'b0)  begin failures++; $display("FAIL rst_en got=%b want=0", d_en); end
    checks++; if (d_addr !== 19'd0) begin failures++; $display("FAIL rst_addr got=%0d want=0", d_addr); end
    checks++; if (d_rgb  !== 24'h0) begin failures++; $display("FAIL rst_rgb got=%h want=0", d_rgb); end
    checks++; if (d_fs   !== 1'b0)  begin failures++; $display("FAIL rst_fs got=%b want=0", d_fs); end
    checks++; if (d_hs   !== 1'b1)  begin failures++; $display("FAIL rst_hs got=%b want=1", d_hs); end
    checks++; if (d_vs   !== 1'b1)  begin failures++; $display("FAIL rst_vs got=%b want=1", d_vs); end
    checks++; if ({s_de, s_fs, s_hs, s_vs} !== 4'b0011) begin failures++; $display("FAIL rst_s2_ctl got=%b want=0011", {s_de, s_fs, s_hs, s_vs}); end
    checks++; if ({m_hs, m_vs} !== 2'b11) begin failures++; $display("FAIL rst_sm_sync got=%b want=11", {m_hs, m_vs}); end
    rst_n = 1'b1;
    wait_cyc(2);
    checks++; if (d_de !== 1'b0) begin failures++; $display("FAIL first_de_early got=%b want=0", d_de); end
    wait_cyc(3);
    checks++; if (d_de !== 1'b1) begin failures++; $display("FAIL first_de got=%b want=1", d_de); end
    checks++; if (d_fs !== 1'b1) begin failures++; $display("FAIL first_fs got=%b want=1", d_fs); end
  endtask

  task automatic test_colour();
    logic [23:0] exp_d [4];
    logic [23:0] exp_s [4];
    exp_d = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hB6B6AA};
    exp_s = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'h00FF00};
    for (int i = 0; i < 4; i++) begin
      wait_cyc(3 + i);
      checks++; if (d_rgb !== exp_d[i]) begin failures++; $display("FAIL colour_x%0d got=%h want=%h", i, d_rgb, exp_d[i]); end
      checks++; if (s_rgb !== exp_s[i]) begin failures++; $display("FAIL colour_s2_x%0d got=%h want=%h", i, s_rgb, exp_s[i]); end
    end
    checks++; if (d_fs !== 1'b0) begin failures++; $display("FAIL fs_one_cycle got=%b want=0", d_fs); end
  endtask

  task automatic test_address_s2();
    logic [18:0] exp_a [4];
    exp_a = '{19'd0, 19'd0, 19'd1, 19'd1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1 + i);
      checks++; if ({s_en, s_addr} !== {1'b1, exp_a[i]}) begin failures++; $display("FAIL s2_addr_x%0d got=%b/%0d want=1/%0d", i, s_en, s_addr, exp_a[i]); end
      checks++; if (d_addr !== 19'(i)) begin failures++; $display("FAIL d_addr_x%0d got=%0d want=%0d", i, d_addr, i); end
    end
    wait_cyc(801);
    checks++; if (s_addr !== 19'd0) begin failures++; $display("FAIL s2_y1_x0 got=%0d want=0", s_addr); end
    wait_cyc(1440);
    checks++; if ({s_en, s_addr} !== {1'b1, 19'd319}) begin failures++; $display("FAIL s2_y1_x639 got=%b/%0d want=1/319", s_en, s_addr); end
    wait_cyc(1441);
    checks++; if (s_en !== 1'b0) begin failures++; $display("FAIL s2_blank_en got=%b want=0", s_en); end
    wait_cyc(1601);
    checks++; if (s_addr !== 19'd320) begin failures++; $display("FAIL s2_y2_x0 got=%0d want=320", s_addr); end
    wait_cyc(1603);
    checks++; if (s_addr !== 19'd321) begin failures++; $display("FAIL s2_y2_x2 got=%0d want=321", s_addr); end
  endtask

  task automatic test_timing_default();
    int de_cnt, hs_cnt, vs_cnt, hs_first;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs_first = -1;
    do_reset();
    for (int n = 3; n <= 802; n++) begin
      wait_cyc(n);
      if (d_de) de_cnt++;
      if (!d_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = n;
      end
      if (!d_vs) vs_cnt++;
    end
    checks++; if (de_cnt !== 640) begin failures++; $display("FAIL line_de_len got=%0d want=640", de_cnt); end
    checks++; if (hs_cnt !== 96) begin failures++; $display("FAIL line_hs_len got=%0d want=96", hs_cnt); end
    checks++; if (hs_first !== 659) begin failures++; $display("FAIL hs_start got=%0d want=659", hs_first); end
    checks++; if (vs_cnt !== 0) begin failures++; $display("FAIL line0_vs got=%0d want=0", vs_cnt); end
    wait_cyc(803);
    checks++; if (d_de !== 1'b1) begin failures++; $display("FAIL line1_de got=%b want=1", d_de); end
  endtask

  task automatic test_frame_small();
    int de_cnt, vs_cnt, vs_first, fs_cnt, max_addr, last_addr;
    de_cnt = 0; vs_cnt = 0; vs_first = -1; fs_cnt = 0; max_addr = 0; last_addr = -1;
    do_reset();
    for (int n = 1; n <= 1177; n++) begin
      wait_cyc(n);
      if (m_de) de_cnt++;
      if (m_fs) fs_cnt++;
      if (!m_vs) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = n;
      end
      if (m_en && int'(m_addr) > max_addr) max_addr = int'(m_addr);
      if (n == 737) last_addr = m_en ? int'(m_addr) : -1;
    end
    checks++; if (de_cnt !== 512) begin failures++; $display("FAIL sm_de_count got=%0d want=512", de_cnt); end
    checks++; if (fs_cnt !== 1) begin failures++; $display("FAIL sm_fs_count got=%0d want=1", fs_cnt); end
    checks++; if (vs_first !== 849) begin failures++; $display("FAIL sm_vs_start got=%0d want=849", vs_first); end
    checks++; if (vs_cnt !== 141) begin failures++; $display("FAIL sm_vs_len got=%0d want=141", vs_cnt); end
    checks++; if (last_addr !== 127) begin failures++; $display("FAIL sm_last_addr got=%0d want=127", last_addr); end
    checks++; if (max_addr !== 127) begin failures++; $display("FAIL sm_max_addr got=%0d want=127", max_addr); end
    wait_cyc(1178);
    checks++; if (m_fs !== 1'b1) begin failures++; $display("FAIL sm_period_fs got=%b want=1", m_fs); end
  endtask

  task automatic test_scan_enable();
    int busy;
    int k;
    busy = 0;
    wait_cyc(1648);
    scan_en_sm = 1'b0;
    wait_cyc(1883);
    checks++; if (m_de !== 1'b1) begin failures++; $display("FAIL scan_frame_completes got=%b want=1", m_de); end
    for (int n = 2353; n < 3553; n++) begin
      wait_cyc(n);
      if (m_de || m_en || m_fs || !m_hs || !m_vs) busy++;
    end
    checks++; if (busy !== 0) begin failures++; $display("FAIL scan_hold_idle got=%0d want=0", busy); end
    k = cyc;
    scan_en_sm = 1'b1;
    wait_cyc(k + 2);
    checks++; if (m_fs !== 1'b0) begin failures++; $display("FAIL scan_restart_early got=%b want=0", m_fs); end
    wait_cyc(k + 3);
    checks++; if ({m_fs, m_de} !== 2'b11) begin failures++; $display("FAIL scan_restart_fs got=%b want=11", {m_fs, m_de}); end
  endtask

  task automatic test_reset_midline();
    do_reset();
    wait_cyc(258);
    checks++; if (m_de !== 1'b1) begin failures++; $display("FAIL mid_pre_de got=%b want=1", m_de); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({m_de, m_en, m_fs} !== 3'b000) begin failures++; $display("FAIL mid_rst_ctl got=%b want=000", {m_de, m_en, m_fs}); end
    checks++; if (m_addr !== 19'd0) begin failures++; $display("FAIL mid_rst_addr got=%0d want=0", m_addr); end
    checks++; if (m_rgb !== 24'h0) begin failures++; $display("FAIL mid_rst_rgb got=%h want=0", m_rgb); end
    checks++; if ({m_hs, m_vs} !== 2'b11) begin failures++; $display("FAIL mid_rst_sync got=%b want=11", {m_hs, m_vs}); end
    rst_n = 1'b1;
    wait_cyc(1);
    checks++; if ({m_en, m_addr} !== {1'b1, 19'd0}) begin failures++; $display("FAIL mid_restart_addr got=%b/%0d want=1/0", m_en, m_addr); end
    wait_cyc(2);
    checks++; if (m_de !== 1'b0) begin failures++; $display("FAIL mid_no_partial got=%b want=0", m_de); end
    wait_cyc(3);
    checks++; if (m_fs !== 1'b1) begin failures++; $display("FAIL mid_restart_fs got=%b want=1", m_fs); end
  endtask

  initial begin
    test_reset();
    test_colour();
    test_address_s2();
    test_timing_default();
    test_frame_small();
    test_scan_enable();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
